// File: rtl/kl_ram_responder.sv
// Single-port 64-bit RAM behind a request/response beat interface with aligned bursts.
// Writes are posted; reads stream one registered beat per cycle under resp_ready backpressure.
module kl_ram_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    input  logic [2:0]  req_size,
    input  logic [4:0]  req_srcid,
    input  logic        req_valid,
    output logic        req_ready,
    output logic [63:0] resp_rdata,
    output logic [2:0]  resp_size,
    output logic [4:0]  resp_dstid,
    output logic        resp_valid,
    input  logic        resp_ready
);

    localparam int unsigned Words = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        StIdle,
        StWburst,
        StRburst
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [3:0]            beats_q, beats_d;
    logic [DEPTH_LOG2-1:0] base_q, base_d;
    logic [2:0]            size_q, size_d;
    logic [4:0]            dstid_q, dstid_d;
    logic [63:0]           rdata_q, rdata_d;
    logic                  resp_valid_q, resp_valid_d;

    logic [63:0]           mem [Words];

    logic [31:0]           req_off;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic [DEPTH_LOG2-1:0] req_base;
    logic [DEPTH_LOG2-1:0] lo_mask;
    logic [1:0]            req_lg;
    logic [3:0]            req_beats;
    logic                  req_hs;
    logic                  resp_hs;
    logic                  beat_last;
    logic [DEPTH_LOG2-1:0] beat_idx;
    logic [DEPTH_LOG2-1:0] next_idx;

    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_widx;
    logic                  rd_en;
    logic [DEPTH_LOG2-1:0] rd_idx;

    logic                  unused_addr_bits;

    // Upper address bits fold away so the array aliases across the whole address space.
    assign req_off          = req_addr - BASE_ADDR;
    assign req_idx          = req_off[DEPTH_LOG2+2:3];
    assign unused_addr_bits = ^{req_off[31:DEPTH_LOG2+3], req_off[2:0]};

    always_comb begin
        req_lg = 2'd0;
        case (req_size)
            3'd4:       req_lg = 2'd1;
            3'd5:       req_lg = 2'd2;
            3'd6, 3'd7: req_lg = 2'd3;
            default:    req_lg = 2'd0;
        endcase
    end

    assign req_beats = 4'd1 << req_lg;
    assign lo_mask   = DEPTH_LOG2'(req_beats - 4'd1);
    assign req_base  = req_idx & ~lo_mask;

    // Base is aligned to the beat count, so these sums never leave the block.
    assign beat_idx  = base_q + DEPTH_LOG2'(cnt_q);
    assign next_idx  = base_q + DEPTH_LOG2'(cnt_q + 4'd1);
    assign beat_last = (cnt_q == (beats_q - 4'd1));

    assign req_ready = rst && (state_q != StRburst);
    assign req_hs    = req_valid && req_ready;
    assign resp_hs   = resp_valid_q && resp_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        beats_d      = beats_q;
        base_d       = base_q;
        size_d       = size_q;
        dstid_d      = dstid_q;
        rdata_d      = rdata_q;
        resp_valid_d = resp_valid_q;
        mem_we       = 1'b0;
        mem_widx     = beat_idx;
        rd_en        = 1'b0;
        rd_idx       = req_base;

        case (state_q)
            StIdle: begin
                if (req_hs) begin
                    base_d  = req_base;
                    beats_d = req_beats;
                    if (req_wen) begin
                        mem_we   = 1'b1;
                        mem_widx = req_base;
                        if (req_beats > 4'd1) begin
                            state_d = StWburst;
                            cnt_d   = 4'd1;
                        end
                    end else begin
                        size_d       = req_size;
                        dstid_d      = req_srcid;
                        cnt_d        = 4'd0;
                        rd_en        = 1'b1;
                        rd_idx       = req_base;
                        resp_valid_d = 1'b1;
                        state_d      = StRburst;
                    end
                end
            end

            StWburst: begin
                // Later beats trust the burst context; req_wen is deliberately not rechecked.
                if (req_hs) begin
                    mem_we   = 1'b1;
                    mem_widx = beat_idx;
                    if (beat_last) begin
                        state_d = StIdle;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

            StRburst: begin
                if (resp_hs) begin
                    if (beat_last) begin
                        resp_valid_d = 1'b0;
                        state_d      = StIdle;
                        cnt_d        = 4'd0;
                    end else begin
                        cnt_d  = cnt_q + 4'd1;
                        rd_en  = 1'b1;
                        rd_idx = next_idx;
                    end
                end
            end

            default: begin
                state_d      = StIdle;
                cnt_d        = 4'd0;
                resp_valid_d = 1'b0;
            end
        endcase

        if (rd_en) begin
            rdata_d = mem[rd_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            beats_q      <= 4'd1;
            base_q       <= '0;
            size_q       <= 3'd0;
            dstid_q      <= 5'd0;
            rdata_q      <= 64'd0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            beats_q      <= beats_d;
            base_q       <= base_d;
            size_q       <= size_d;
            dstid_q      <= dstid_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // Array has no reset so contents survive rst; req_ready gates writes while in reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (req_wmask[b]) begin
                    mem[mem_widx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_size  = size_q;
    assign resp_dstid = dstid_q;
    assign resp_valid = resp_valid_q;

endmodule

// File: doc/kl_ram_responder.md
KL_RAM_RESPONDER -- requirements
Module: kl_ram_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 10, giving the log2 of the 64-bit word count (1024 words, 8 KiB).
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0, which is subtracted from req_addr before the word index is formed.
REQ-003 The block SHALL have the following ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- req_addr  in  32  request byte address.
- req_wen  in  1  1 = write, 0 = read.
- req_wdata  in  64  write data beat.
- req_wmask  in  8  byte-write enables; bit i covers wdata[8i+7:8i].
- req_size  in  3  log2 transfer bytes.
- req_srcid  in  5  requester ID.
- req_valid  in  1  request beat valid.
- req_ready  out  1  request beat accepted when high together with req_valid.
- resp_rdata  out  64  read data beat.
- resp_size  out  3  echo of the captured req_size.
- resp_dstid  out  5  echo of the captured req_srcid.
- resp_valid  out  1  response beat valid.
- resp_ready  in  1  response beat consumed when high together with resp_valid.

Function
REQ-004 Word index SHALL be (req_addr - BASE_ADDR)[DEPTH_LOG2+2:3]; higher bits are ignored, so addresses alias modulo 8*2^DEPTH_LOG2 bytes.
REQ-005 Beat count SHALL depend on req_size:
- 0..3: 1 beat.
- 4: 2 beats.
- 5: 4 beats.
- 6: 8 beats.
- 7: treated as 6.
REQ-006 The burst base SHALL be the word index with its low log2(beats) bits cleared; beat k SHALL address base+k, with no wrap outside the aligned block.
REQ-007 The FSM SHALL have states IDLE, WBURST and RBURST, and SHALL be in IDLE after reset.
REQ-008 req_ready SHALL be 1 in IDLE and WBURST, 0 in RBURST, and 0 whenever rst is low.
REQ-009 An IDLE write handshake SHALL update the base word with its bytes selected by req_wmask.
- If beats > 1, the FSM SHALL go to WBURST with a beat counter of 1.
- Otherwise the FSM SHALL stay in IDLE.
REQ-010 In WBURST, each handshake SHALL write req_wdata/req_wmask to base+counter, ignoring req_addr, req_size and req_srcid, and SHALL increment the counter.
REQ-011 WBURST SHALL return to IDLE on the handshake of the last beat.
REQ-012 A WBURST beat arriving with req_wen=0 SHALL be written regardless, since wen is not rechecked.
REQ-013 Writes SHALL be posted: no response beat is generated.
REQ-014 An IDLE read handshake SHALL capture base, beat count, req_size and req_srcid, and the FSM SHALL go to RBURST.
REQ-015 The first read beat SHALL assert resp_valid on the cycle after the handshake, carrying mem[base], the captured size and the captured srcid.
REQ-016 While resp_valid=1 and resp_ready=0, resp_rdata, resp_size and resp_dstid SHALL hold stable.
REQ-017 On each response handshake that is not the last beat, the next beat SHALL be presented on the following cycle (one beat per cycle when resp_ready is held high).
REQ-018 On the last-beat handshake, resp_valid SHALL drop the next cycle and the FSM SHALL return to IDLE, with req_ready high that same next cycle.
REQ-019 Sizes 0..2 SHALL read and return the full 64-bit word; the requester extracts its lanes.
REQ-020 resp_valid SHALL be 0 in IDLE and WBURST.
REQ-021 Read data SHALL come from a registered memory read, so a write beat fully precedes any later read of the same word.
REQ-022 Memory array contents SHALL NOT be reset; they are X until written.

Reset
REQ-023 While rst=0, the block SHALL force:
- state=IDLE, beat counter=0;
- resp_valid=0, resp_rdata=0, resp_size=0, resp_dstid=0;
- req_ready=0.
REQ-024 Reset asserted mid-burst SHALL abandon the burst; the partially written words SHALL keep the beats already written.
REQ-025 Reset SHALL NOT corrupt memory contents.
REQ-026 After rst deasserts, req_ready SHALL be 1 at the first clock edge.

Verification
REQ-027 Single write/read: write addr 0x10, wdata 0x1122334455667788, wmask 0xFF; then read addr 0x10, size 3, srcid 5 -> one beat 0x1122334455667788, resp_dstid=5, resp_size=3, valid on handshake+1.
REQ-028 Byte mask: word 0x18 holds 0; write wdata all-ones, wmask 0x0F -> a read returns 0x00000000FFFFFFFF.
REQ-029 Burst write/read with backpressure: size 6 write at 0x40 with data k for beats 0..7; size 6 read at 0x44 (unaligned), resp_ready toggling 1/0 -> beats 0..7 delivered in order, each held while ready is low; req_ready=0 throughout.
REQ-030 Aliasing: with DEPTH_LOG2=10, write at 0x2008 -> a read at 0x0008 returns the same data.
REQ-031 Reset mid-read: assert rst on beat 2 of a size 5 read -> resp_valid=0 immediately; after release req_ready=1 and memory is unchanged.
REQ-032 Back-to-back: a read request presented continuously while the last beat completes -> accepted on the cycle req_ready rises, and its first beat appears one cycle later.
